// File: rtl/e_stage_reg.sv
// rtl/e_stage_reg.sv - D/E pipeline register with freeze, bubble insertion, Tnew countdown and bubble counter
module e_stage_reg #(
    parameter int DW = 32,
    parameter int TW = 2,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] pcD,
    input  logic [DW-1:0] instrD,
    input  logic [DW-1:0] rsDataD,
    input  logic [DW-1:0] rtDataD,
    input  logic [DW-1:0] imm32D,
    input  logic [4:0]    a3D,
    input  logic [TW-1:0] tnewD,
    output logic [DW-1:0] pcE,
    output logic [DW-1:0] instrE,
    output logic [DW-1:0] rsDataE,
    output logic [DW-1:0] rtDataE,
    output logic [DW-1:0] imm32E,
    output logic [4:0]    a3E,
    output logic [TW-1:0] tnewE,
    output logic [TW-1:0] tnewNextM,
    output logic          validE,
    output logic [CW-1:0] bubbleCnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcE     <= '0;
            instrE  <= '0;
            rsDataE <= '0;
            rtDataE <= '0;
            imm32E  <= '0;
            a3E     <= '0;
            tnewE   <= '0;
            validE  <= 1'b0;
        end else if (clr) begin
            // A bubble keeps the stalled PC so exception/debug views stay meaningful.
            pcE     <= pcD;
            instrE  <= '0;
            rsDataE <= '0;
            rtDataE <= '0;
            imm32E  <= '0;
            a3E     <= '0;
            tnewE   <= '0;
            validE  <= 1'b0;
        end else if (en) begin
            pcE     <= pcD;
            instrE  <= instrD;
            rsDataE <= rsDataD;
            rtDataE <= rtDataD;
            imm32E  <= imm32D;
            a3E     <= a3D;
            tnewE   <= tnewD;
            validE  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubbleCnt <= '0;
        end else if (clr && (bubbleCnt != {CW{1'b1}})) begin
            bubbleCnt <= bubbleCnt + CW'(1);
        end
    end

    assign tnewNextM = (tnewE == '0) ? '0 : tnewE - TW'(1);

endmodule

// File: tb/tb_e_stage_reg.sv
// tb/tb_e_stage_reg.sv - directed self-checking bench for e_stage_reg
module tb_e_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, clr;
    logic [31:0] pcD, instrD, rsDataD, rtDataD, imm32D;
    logic [4:0]  a3D;
    logic [1:0]  tnewD;
    logic [31:0] pcE, instrE, rsDataE, rtDataE, imm32E;
    logic [4:0]  a3E;
    logic [1:0]  tnewE, tnewNextM;
    logic        validE;
    logic [31:0] bubbleCnt;

    logic [31:0] pcE4, instrE4, rsDataE4, rtDataE4, imm32E4;
    logic [4:0]  a3E4;
    logic [1:0]  tnewE4, tnewNextM4;
    logic        validE4;
    logic [3:0]  bubbleCnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    e_stage_reg dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .pcD(pcD), .instrD(instrD), .rsDataD(rsDataD), .rtDataD(rtDataD),
        .imm32D(imm32D), .a3D(a3D), .tnewD(tnewD),
        .pcE(pcE), .instrE(instrE), .rsDataE(rsDataE), .rtDataE(rtDataE),
        .imm32E(imm32E), .a3E(a3E), .tnewE(tnewE), .tnewNextM(tnewNextM),
        .validE(validE), .bubbleCnt(bubbleCnt)
    );

    e_stage_reg #(.CW(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .clr(clr),
        .pcD(pcD), .instrD(instrD), .rsDataD(rsDataD), .rtDataD(rtDataD),
        .imm32D(imm32D), .a3D(a3D), .tnewD(tnewD),
        .pcE(pcE4), .instrE(instrE4), .rsDataE(rsDataE4), .rtDataE(rtDataE4),
        .imm32E(imm32E4), .a3E(a3E4), .tnewE(tnewE4), .tnewNextM(tnewNextM4),
        .validE(validE4), .bubbleCnt(bubbleCnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_d();
        pcD = $urandom; instrD = $urandom; rsDataD = $urandom; rtDataD = $urandom;
        imm32D = $urandom; a3D = 5'($urandom); tnewD = 2'($urandom);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; clr = 1'b1;
        rand_d();
        step();
        rand_d();
        step();
        chk("rst_pcE", pcE, 32'h0);
        chk("rst_instrE", instrE, 32'h0);
        chk("rst_rsDataE", rsDataE, 32'h0);
        chk("rst_rtDataE", rtDataE, 32'h0);
        chk("rst_imm32E", imm32E, 32'h0);
        chk("rst_a3E", 32'(a3E), 32'h0);
        chk("rst_tnewE", 32'(tnewE), 32'h0);
        chk("rst_tnewNextM", 32'(tnewNextM), 32'h0);
        chk("rst_validE", 32'(validE), 32'h0);
        chk("rst_bubbleCnt", bubbleCnt, 32'h0);
        chk("rst_bubbleCnt4", 32'(bubbleCnt4), 32'h0);

        // Normal capture of a lui
        reset = 1'b0; en = 1'b1; clr = 1'b0;
        pcD = 32'h0000_3004; instrD = 32'h3C01_ABCD; rsDataD = 32'h1111_1111;
        rtDataD = 32'h2222_2222; imm32D = 32'hABCD_0000; a3D = 5'd1; tnewD = 2'd1;
        step();
        chk("cap_pcE", pcE, 32'h0000_3004);
        chk("cap_instrE", instrE, 32'h3C01_ABCD);
        chk("cap_rsDataE", rsDataE, 32'h1111_1111);
        chk("cap_rtDataE", rtDataE, 32'h2222_2222);
        chk("cap_imm32E", imm32E, 32'hABCD_0000);
        chk("cap_a3E", 32'(a3E), 32'd1);
        chk("cap_tnewE", 32'(tnewE), 32'd1);
        chk("cap_tnewNextM", 32'(tnewNextM), 32'd0);
        chk("cap_validE", 32'(validE), 32'd1);
        chk("cap_bubbleCnt", bubbleCnt, 32'd0);

        // Hold: D inputs change but E stays frozen
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            step();
            chk("hold_pcE", pcE, 32'h0000_3004);
            chk("hold_instrE", instrE, 32'h3C01_ABCD);
            chk("hold_imm32E", imm32E, 32'hABCD_0000);
            chk("hold_a3E", 32'(a3E), 32'd1);
            chk("hold_tnewE", 32'(tnewE), 32'd1);
            chk("hold_validE", 32'(validE), 32'd1);
        end

        // Bubble while frozen
        clr = 1'b1; en = 1'b0; pcD = 32'h0000_3008;
        step();
        chk("bub_pcE", pcE, 32'h0000_3008);
        chk("bub_instrE", instrE, 32'h0);
        chk("bub_rsDataE", rsDataE, 32'h0);
        chk("bub_imm32E", imm32E, 32'h0);
        chk("bub_a3E", 32'(a3E), 32'h0);
        chk("bub_tnewE", 32'(tnewE), 32'h0);
        chk("bub_validE", 32'(validE), 32'h0);
        chk("bub_cnt1", bubbleCnt, 32'd1);
        step();
        step();
        chk("bub_cnt3", bubbleCnt, 32'd3);
        chk("bub_cnt3_w4", 32'(bubbleCnt4), 32'd3);
        chk("bub_pcE3", pcE, 32'h0000_3008);

        // reset beats clr
        reset = 1'b1; clr = 1'b1; pcD = 32'h0000_300C;
        step();
        chk("prio_cnt", bubbleCnt, 32'd0);
        chk("prio_pcE", pcE, 32'h0);
        chk("prio_validE", 32'(validE), 32'd0);

        // Saturation on the CW=4 instance
        reset = 1'b0; clr = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat_cnt4", 32'(bubbleCnt4), (i > 15) ? 32'd15 : 32'(i));
        end
        chk("sat_cnt32", bubbleCnt, 32'd20);

        clr = 1'b0; en = 1'b1; tnewD = 2'd2; a3D = 5'd3;
        step();
        chk("sat_hold4", 32'(bubbleCnt4), 32'd15);
        chk("t2_tnewE", 32'(tnewE), 32'd2);
        chk("t2_tnewNextM", 32'(tnewNextM), 32'd1);
        chk("t2_validE", 32'(validE), 32'd1);
        tnewD = 2'd0;
        step();
        chk("t0_tnewNextM", 32'(tnewNextM), 32'd0);
        tnewD = 2'd3;
        step();
        chk("t3_tnewNextM", 32'(tnewNextM), 32'd2);

        // Mid-operation reset discards the instruction
        reset = 1'b1;
        step();
        chk("mrst_validE", 32'(validE), 32'd0);
        chk("mrst_instrE", instrE, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
